audio_transport_ctrl: RTL and testbench
=======================================

// Module: audio_transport_ctrl
// PURPOSE
//  Transport sequencer for the SD-card audio path (FIFO -> playback sync -> PWM). Turns
//  play/pause/stop pulses from game logic into enable_audio/reset_audio, holds playback
//  until the FIFO is prefilled, and keeps a millisecond song-position counter from
//  consumed samples for hit-object timing. Sits between game FSM and audio path top.
// PARAMETERS
//  RESET_CYCLES     16        cycles reset_audio is held high per rewind (>=2)
//  PREFILL_TIMEOUT  2_000_000 max cycles in PREFILL waiting for fifo_full
//  SAMPLE_RATE_HZ   44100     sample rate; ms timebase denominator
//  MS_W             20        song_ms width (~17 min range)
// PORTS
//  Clk            in   1     system clock
//  reset_rtl_0    in   1     asynchronous active-high reset
//  play_req       in   1     1-cycle pulse: start from top / resume from pause
//  pause_req      in   1     1-cycle pulse: pause playback
//  stop_req       in   1     1-cycle pulse: stop, rewind, clear position
//  sd_init_done   in   1     SD card init complete (level)
//  sd_init_error  in   1     SD card init failed (level)
//  fifo_full      in   1     audio FIFO full
//  fifo_empty     in   1     audio FIFO empty
//  sample_tick    in   1     1-cycle pulse per sample consumed (playback fifo_rd_en)
//  enable_audio   out  1     playback enable to audio path
//  reset_audio    out  1     rewind reset to FIFO/sync/PWM/SD init
//  playing        out  1     high only in PLAY
//  song_ms        out  MS_W  elapsed song time, ms
//  underrun       out  1     sticky: sample_tick seen with fifo_empty during PLAY
//  err            out  1     high in ERROR
// BEHAVIOUR
//  - Async reset: state IDLE; all outputs 0; counters/accumulator 0.
//  - All outputs registered; response visible 1 cycle after the request edge.
//  - Request priority same cycle: stop > play > pause; lower one dropped.
//  - States: IDLE, REWIND, PREFILL, PLAY, PAUSE, ERROR.
//    IDLE:    play -> REWIND (go_play=1). stop/pause ignored.
//    REWIND:  reset_audio=1 for exactly RESET_CYCLES; song_ms, accumulator, underrun
//             cleared. At end: go_play ? PREFILL : IDLE. stop here clears go_play.
//    PREFILL: enable_audio=0. fifo_full -> PLAY. sd_init_error -> ERROR. Timeout:
//             !fifo_empty -> PLAY, else ERROR. stop -> REWIND(go_play=0).
//    PLAY:    enable_audio=1, playing=1. pause -> PAUSE. stop -> REWIND(go_play=0).
//             play ignored. sd_init_error -> ERROR.
//    PAUSE:   enable_audio=0; song_ms frozen. play -> PLAY (no rewind, no prefill).
//             stop -> REWIND(go_play=0).
//    ERROR:   err=1, enable_audio=0. Only stop leaves (-> REWIND, go_play=0).
//  - Timebase: on sample_tick in PLAY only, acc += 1000; if acc >= SAMPLE_RATE_HZ then
//    acc -= SAMPLE_RATE_HZ and song_ms++ (same cycle). acc width clog2(SAMPLE_RATE_HZ+1000).
//    song_ms saturates at all-ones (no wrap). sample_tick outside PLAY ignored.
//  - underrun set on sample_tick & fifo_empty in PLAY; cleared only by REWIND/reset.
//  - Reset mid-REWIND/PREFILL: returns to IDLE immediately, no residual pulse.
// STRUCTURE
//  - Package audio_ctrl_pkg: typedef enum logic [2:0] xport_state_t; localparam
//    MS_PER_SEC=1000; shared by game FSM for state decode.
//  - Sub-module audio_ms_timebase: fractional accumulator + saturating song_ms
//    (inputs: tick, clear; output song_ms). Rest is one FSM + REWIND/timeout counters.
// TESTING
//  1 play in IDLE -> reset_audio high exactly 16 cycles, then PREFILL; fifo_full -> PLAY,
//    enable_audio=1 next cycle.
//  2 PLAY, 44100 sample_ticks -> song_ms=1000, acc=0; 441 ticks -> song_ms=10.
//  3 pause, 500 ticks, play -> song_ms unchanged while paused; no reset_audio on resume.
//  4 stop+play same cycle in PLAY -> REWIND with go_play=0, ends in IDLE, song_ms=0.
//  5 PREFILL, fifo_empty held past PREFILL_TIMEOUT -> ERROR, err=1; stop -> REWIND -> IDLE.
//  6 PLAY, sample_tick with fifo_empty -> underrun=1, stays set until next REWIND;
//    async reset mid-REWIND -> all outputs 0 immediately.

Source files
------------

// File: rtl/audio_ctrl_pkg.sv
// rtl/audio_ctrl_pkg.sv - transport state encoding and timebase constants
// Shared with the game FSM so it can decode the transport state directly.
package audio_ctrl_pkg;

    typedef enum logic [2:0] {
        XS_IDLE    = 3'd0,
        XS_REWIND  = 3'd1,
        XS_PREFILL = 3'd2,
        XS_PLAY    = 3'd3,
        XS_PAUSE   = 3'd4,
        XS_ERROR   = 3'd5
    } xport_state_t;

    localparam int MS_PER_SEC = 1000;

endpackage

// File: rtl/audio_ms_timebase.sv
// rtl/audio_ms_timebase.sv - sample-count to millisecond song position
// Ports: clk, rst (async, active high); tick = one consumed sample to count;
// clear = zero position and fraction; song_ms = elapsed ms, saturating.
module audio_ms_timebase
    import audio_ctrl_pkg::*;
#(
    parameter int SAMPLE_RATE_HZ = 44100,
    parameter int MS_W           = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            clear,
    output logic [MS_W-1:0] song_ms
);

    // Fraction of a millisecond in units of 1/SAMPLE_RATE_HZ ms; each sample
    // adds MS_PER_SEC, so no divider is needed and there is no drift.
    localparam int ACC_W = $clog2(SAMPLE_RATE_HZ + MS_PER_SEC);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;

    assign acc_sum = acc + ACC_W'(MS_PER_SEC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            song_ms <= '0;
        end else if (clear) begin
            acc     <= '0;
            song_ms <= '0;
        end else if (tick) begin
            if (acc_sum >= ACC_W'(SAMPLE_RATE_HZ)) begin
                acc <= acc_sum - ACC_W'(SAMPLE_RATE_HZ);
                if (song_ms != '1) begin
                    song_ms <= song_ms + MS_W'(1);
                end
            end else begin
                acc <= acc_sum;
            end
        end
    end

endmodule

// File: rtl/audio_transport_ctrl.sv
// rtl/audio_transport_ctrl.sv - play/pause/stop sequencer for the audio path
// Ports: Clk, reset_rtl_0 (async, active high); play_req/pause_req/stop_req
// one-cycle requests (stop > play > pause); sd_init_done/sd_init_error SD
// status; fifo_full/fifo_empty FIFO level; sample_tick per consumed sample.
// Outputs (all registered): enable_audio, reset_audio, playing, song_ms,
// underrun (sticky until rewind), err.
module audio_transport_ctrl
    import audio_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES    = 16,
    parameter int PREFILL_TIMEOUT = 2_000_000,
    parameter int SAMPLE_RATE_HZ  = 44100,
    parameter int MS_W            = 20
) (
    input  logic            Clk,
    input  logic            reset_rtl_0,
    input  logic            play_req,
    input  logic            pause_req,
    input  logic            stop_req,
    input  logic            sd_init_done,
    input  logic            sd_init_error,
    input  logic            fifo_full,
    input  logic            fifo_empty,
    input  logic            sample_tick,
    output logic            enable_audio,
    output logic            reset_audio,
    output logic            playing,
    output logic [MS_W-1:0] song_ms,
    output logic            underrun,
    output logic            err
);

    localparam int RW_W = $clog2(RESET_CYCLES);
    localparam int PF_W = $clog2(PREFILL_TIMEOUT + 1);

    xport_state_t    state;
    xport_state_t    state_nxt;
    logic            go_play;
    logic            go_play_nxt;
    logic [RW_W-1:0] rw_cnt;
    logic [PF_W-1:0] pf_cnt;
    logic            rw_done;
    logic            pf_timeout;

    // A full FIFO already implies the card came up, so init completion is
    // not needed for sequencing; kept on the port list for the audio top.
    logic unused_sd_init_done;
    assign unused_sd_init_done = sd_init_done;

    assign rw_done    = (rw_cnt == RW_W'(RESET_CYCLES - 1));
    assign pf_timeout = (pf_cnt == PF_W'(PREFILL_TIMEOUT - 1));

    always_comb begin
        state_nxt   = state;
        go_play_nxt = go_play;
        case (state)
            XS_IDLE: begin
                if (play_req) begin
                    state_nxt   = XS_REWIND;
                    go_play_nxt = 1'b1;
                end
            end
            XS_REWIND: begin
                // stop during rewind only cancels the pending start; the
                // reset pulse still runs its full length
                if (stop_req) go_play_nxt = 1'b0;
                if (rw_done) state_nxt = go_play_nxt ? XS_PREFILL : XS_IDLE;
            end
            XS_PREFILL: begin
                if (stop_req) begin
                    state_nxt   = XS_REWIND;
                    go_play_nxt = 1'b0;
                end else if (sd_init_error) begin
                    state_nxt = XS_ERROR;
                end else if (fifo_full) begin
                    state_nxt = XS_PLAY;
                end else if (pf_timeout) begin
                    // a partly filled FIFO is good enough to start on
                    state_nxt = fifo_empty ? XS_ERROR : XS_PLAY;
                end
            end
            XS_PLAY: begin
                if (stop_req) begin
                    state_nxt   = XS_REWIND;
                    go_play_nxt = 1'b0;
                end else if (sd_init_error) begin
                    state_nxt = XS_ERROR;
                end else if (pause_req) begin
                    state_nxt = XS_PAUSE;
                end
            end
            XS_PAUSE: begin
                if (stop_req) begin
                    state_nxt   = XS_REWIND;
                    go_play_nxt = 1'b0;
                end else if (play_req) begin
                    state_nxt = XS_PLAY;
                end
            end
            XS_ERROR: begin
                if (stop_req) begin
                    state_nxt   = XS_REWIND;
                    go_play_nxt = 1'b0;
                end
            end
            default: state_nxt = XS_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset_rtl_0) begin
        if (reset_rtl_0) begin
            state        <= XS_IDLE;
            go_play      <= 1'b0;
            rw_cnt       <= '0;
            pf_cnt       <= '0;
            enable_audio <= 1'b0;
            reset_audio  <= 1'b0;
            playing      <= 1'b0;
            err          <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state   <= state_nxt;
            go_play <= go_play_nxt;
            rw_cnt  <= (state == XS_REWIND && state_nxt == XS_REWIND) ? rw_cnt + 1'b1 : '0;
            pf_cnt  <= (state == XS_PREFILL && state_nxt == XS_PREFILL) ? pf_cnt + 1'b1 : '0;
            // outputs follow the next state so they line up with it
            enable_audio <= (state_nxt == XS_PLAY);
            playing      <= (state_nxt == XS_PLAY);
            reset_audio  <= (state_nxt == XS_REWIND);
            err          <= (state_nxt == XS_ERROR);
            if (state_nxt == XS_REWIND) begin
                underrun <= 1'b0;
            end else if (state == XS_PLAY && sample_tick && fifo_empty) begin
                underrun <= 1'b1;
            end
        end
    end

    audio_ms_timebase #(
        .SAMPLE_RATE_HZ (SAMPLE_RATE_HZ),
        .MS_W           (MS_W)
    ) u_timebase (
        .clk     (Clk),
        .rst     (reset_rtl_0),
        .tick    ((state == XS_PLAY) && sample_tick),
        .clear   (state_nxt == XS_REWIND),
        .song_ms (song_ms)
    );

endmodule

// File: tb/tb_audio_transport_ctrl.sv
// tb/tb_audio_transport_ctrl.sv - self-checking bench for audio_transport_ctrl
module tb_audio_transport_ctrl;

    localparam int RESET_CYCLES    = 16;
    localparam int PREFILL_TIMEOUT = 40;
    localparam int SAMPLE_RATE_HZ  = 44100;
    localparam int MS_W            = 20;
    localparam longint MS_MAX      = (longint'(1) << MS_W) - 1;

    logic            Clk;
    logic            reset_rtl_0;
    logic            play_req, pause_req, stop_req;
    logic            sd_init_done, sd_init_error;
    logic            fifo_full, fifo_empty, sample_tick;
    logic            enable_audio, reset_audio, playing, underrun, err;
    logic [MS_W-1:0] song_ms;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 0;

    audio_transport_ctrl #(
        .RESET_CYCLES    (RESET_CYCLES),
        .PREFILL_TIMEOUT (PREFILL_TIMEOUT),
        .SAMPLE_RATE_HZ  (SAMPLE_RATE_HZ),
        .MS_W            (MS_W)
    ) dut (
        .Clk           (Clk),
        .reset_rtl_0   (reset_rtl_0),
        .play_req      (play_req),
        .pause_req     (pause_req),
        .stop_req      (stop_req),
        .sd_init_done  (sd_init_done),
        .sd_init_error (sd_init_error),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .sample_tick   (sample_tick),
        .enable_audio  (enable_audio),
        .reset_audio   (reset_audio),
        .playing       (playing),
        .song_ms       (song_ms),
        .underrun      (underrun),
        .err           (err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference model: transport mode, remaining rewind cycles, cycles spent
    // prefilling, and the raw count of samples played since the last rewind.
    typedef enum {M_IDLE, M_REWIND, M_PREFILL, M_PLAY, M_PAUSE, M_ERROR} mode_t;
    mode_t  m_mode      = M_IDLE;
    int     m_rw_left   = 0;
    int     m_pf_elapsed = 0;
    bit     m_go        = 0;
    bit     m_underrun  = 0;
    longint m_samples   = 0;

    function automatic longint exp_song_ms();
        longint v;
        v = (m_samples * 1000) / SAMPLE_RATE_HZ;
        return (v > MS_MAX) ? MS_MAX : v;
    endfunction

    task automatic enter_rewind(input bit go);
        m_mode     = M_REWIND;
        m_rw_left  = RESET_CYCLES;
        m_go       = go;
        m_samples  = 0;
        m_underrun = 0;
    endtask

    initial begin
        forever begin
            @(posedge Clk or posedge reset_rtl_0);
            if (reset_rtl_0) begin
                m_mode = M_IDLE; m_rw_left = 0; m_pf_elapsed = 0;
                m_go = 0; m_underrun = 0; m_samples = 0;
            end else begin
                case (m_mode)
                    M_IDLE: if (play_req) enter_rewind(1);
                    M_REWIND: begin
                        if (stop_req) m_go = 0;
                        m_rw_left--;
                        if (m_rw_left == 0) begin
                            m_mode = m_go ? M_PREFILL : M_IDLE;
                            m_pf_elapsed = 0;
                        end
                    end
                    M_PREFILL: begin
                        m_pf_elapsed++;
                        if (stop_req) enter_rewind(0);
                        else if (sd_init_error) m_mode = M_ERROR;
                        else if (fifo_full) m_mode = M_PLAY;
                        else if (m_pf_elapsed >= PREFILL_TIMEOUT) m_mode = fifo_empty ? M_ERROR : M_PLAY;
                    end
                    M_PLAY: begin
                        if (sample_tick) begin
                            m_samples++;
                            if (fifo_empty) m_underrun = 1;
                        end
                        if (stop_req) enter_rewind(0);
                        else if (sd_init_error) m_mode = M_ERROR;
                        else if (pause_req) m_mode = M_PAUSE;
                    end
                    M_PAUSE: begin
                        if (stop_req) enter_rewind(0);
                        else if (play_req) m_mode = M_PLAY;
                    end
                    M_ERROR: if (stop_req) enter_rewind(0);
                    default: m_mode = M_IDLE;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            if (check_en) begin
                check("enable_audio", enable_audio, m_mode == M_PLAY);
                check("playing", playing, m_mode == M_PLAY);
                check("reset_audio", reset_audio, m_mode == M_REWIND);
                check("err", err, m_mode == M_ERROR);
                check("underrun", underrun, m_underrun);
                check("song_ms", song_ms, exp_song_ms());
            end
        end
    end

    task automatic drive(input bit p, input bit pa, input bit s, input bit t);
        @(negedge Clk);
        play_req = p; pause_req = pa; stop_req = s; sample_tick = t;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) drive(0, 0, 0, 0);
    endtask

    task automatic start_play();
        fifo_empty = 0;
        fifo_full  = 1;
        drive(1, 0, 0, 0);
        idle_cycles(RESET_CYCLES + 2);
        fifo_full = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enable"}, enable_audio, 0);
        check({tag, "_reset_audio"}, reset_audio, 0);
        check({tag, "_playing"}, playing, 0);
        check({tag, "_song_ms"}, song_ms, 0);
        check({tag, "_underrun"}, underrun, 0);
        check({tag, "_err"}, err, 0);
    endtask

    int n_hi;
    bit rst_seen;

    initial begin
        reset_rtl_0 = 1; play_req = 0; pause_req = 0; stop_req = 0;
        sd_init_done = 1; sd_init_error = 0; fifo_full = 0; fifo_empty = 0; sample_tick = 0;
        repeat (3) @(negedge Clk);
        check_all_zero("in_reset");
        reset_rtl_0 = 0;
        idle_cycles(2);
        check_en = 1;
        check_all_zero("after_reset");

        // rewind length and prefill -> play
        drive(1, 0, 0, 0);
        n_hi = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0);
            if (reset_audio) n_hi++;
        end
        check("rewind_len", n_hi, 16);
        fifo_full = 1;
        drive(0, 0, 0, 0);
        fifo_full = 0;
        check("play_enable", enable_audio, 1);
        check("play_playing", playing, 1);

        // one second of samples
        repeat (44100) drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        check("song_1s", song_ms, 1000);

        drive(0, 0, 1, 0);
        idle_cycles(RESET_CYCLES + 2);
        start_play();
        repeat (441) drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        check("song_441", song_ms, 10);

        // pause freezes position, resume does not rewind
        drive(0, 1, 0, 0);
        repeat (500) drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        check("paused_song", song_ms, 10);
        check("paused_playing", playing, 0);
        drive(1, 0, 0, 0);
        rst_seen = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            if (reset_audio) rst_seen = 1;
        end
        check("resume_no_rewind", rst_seen, 0);
        check("resume_playing", playing, 1);
        repeat (50) drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        check("song_491", song_ms, 11);

        // stop wins over play: rewind then idle
        drive(1, 0, 1, 0);
        idle_cycles(RESET_CYCLES + 4);
        check("stop_play_song", song_ms, 0);
        check("stop_play_reset", reset_audio, 0);
        check("stop_play_enable", enable_audio, 0);
        fifo_empty = 1;
        idle_cycles(PREFILL_TIMEOUT + 20);
        check("stop_play_idle_err", err, 0);

        // prefill timeout with an empty FIFO
        drive(1, 0, 0, 0);
        idle_cycles(RESET_CYCLES + PREFILL_TIMEOUT + 3);
        check("timeout_err", err, 1);
        check("timeout_enable", enable_audio, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        check("err_stop_rewind", reset_audio, 1);
        check("err_stop_err", err, 0);
        idle_cycles(RESET_CYCLES + 2);
        check("err_stop_done", reset_audio, 0);
        idle_cycles(PREFILL_TIMEOUT + 10);
        check("err_stop_idle", err, 0);

        // sticky underrun
        start_play();
        repeat (10) drive(0, 0, 0, 1);
        fifo_empty = 1;
        drive(0, 0, 0, 1);
        fifo_empty = 0;
        drive(0, 0, 0, 0);
        check("underrun_set", underrun, 1);
        drive(0, 1, 0, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("underrun_sticky", underrun, 1);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        check("underrun_cleared", underrun, 0);
        idle_cycles(RESET_CYCLES + 2);

        // async reset in the middle of a rewind
        drive(1, 0, 0, 0);
        idle_cycles(5);
        check("mid_rewind", reset_audio, 1);
        check_en = 0;
        #1 reset_rtl_0 = 1;
        #1 check_all_zero("async_reset");
        idle_cycles(2);
        reset_rtl_0 = 0;
        drive(0, 0, 0, 0);
        check_en = 1;
        idle_cycles(RESET_CYCLES + 4);
        check("post_reset_reset_audio", reset_audio, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            fifo_full  = ($urandom_range(0, 7) == 0);
            fifo_empty = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) sd_init_error = ~sd_init_error;
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
        end
        sd_init_error = 0;
        idle_cycles(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
